// File: rtl/fetch_buffer_pkg.sv
// Shared constants for the fetch/decode boundary.
// The NOP encoding is used by every stage that inserts bubbles.
package fetch_buffer_pkg;

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
    localparam int          DEFAULT_DEPTH = 4;
    localparam int          DEFAULT_WIDTH = 32;

endpackage : fetch_buffer_pkg

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: a small circular FIFO between fetch and decode.
// The head entry is presented to decode; empty slots read as NOP with PC 0.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_valid,
    input  logic [WIDTH-1:0]         i_instr,
    input  logic [31:0]              i_pc,
    output logic                     o_ready,
    input  logic                     i_en,
    output logic [WIDTH-1:0]         o_instr,
    output logic [31:0]              o_pc,
    output logic                     o_imask,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP_INSTR);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic [WIDTH-1:0] instr_mem_q [DEPTH];
    logic [31:0]      pc_mem_q    [DEPTH];

    logic push;
    logic pop;

    assign o_ready = (count_q != CNT_W'(DEPTH));
    assign o_imask = (count_q != '0);
    assign o_count = count_q;

    // A push while full is dropped even if a pop frees a slot in the same cycle.
    assign push = i_valid && o_ready && !i_flush;
    assign pop  = i_en && o_imask && !i_flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; the occupancy count alone decides which slots are meaningful.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && push) begin
            instr_mem_q[wr_ptr_q] <= i_instr;
            pc_mem_q[wr_ptr_q]    <= i_pc;
        end
    end

    assign o_instr = o_imask ? instr_mem_q[rd_ptr_q] : NOP_W;
    assign o_pc    = o_imask ? pc_mem_q[rd_ptr_q]    : 32'h0;

endmodule : fetch_buffer

// File: tb/tb_fetch_buffer.sv
// Directed, table-driven bench for fetch_buffer at DEPTH=4, WIDTH=32.
// Each vector applies inputs for one cycle and checks the outputs after the edge.
module tb_fetch_buffer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ready;
    logic        en;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        imask;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic        valid;
        logic        en;
        logic [31:0] pc;
        logic [2:0]  exp_count;
        logic        exp_imask;
        logic        exp_ready;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    fetch_buffer #(.DEPTH(4), .WIDTH(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .i_valid (valid),
        .i_instr (instr),
        .i_pc    (pc),
        .o_ready (ready),
        .i_en    (en),
        .o_instr (o_instr),
        .o_pc    (o_pc),
        .o_imask (imask),
        .o_count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 time units");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] instr_of(input logic [31:0] p);
        return 32'h1000_0000 + p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic f, input logic v, input logic e,
                       input logic [31:0] p, input logic [2:0] c, input logic im,
                       input logic rd, input logic [31:0] hp);
        vec_t t;
        t.rst_n = r;  t.flush = f;  t.valid = v;  t.en = e;  t.pc = p;
        t.exp_count = c;  t.exp_imask = im;  t.exp_ready = rd;  t.exp_pc = hp;
        vecs.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        rst_n = t.rst_n;
        flush = t.flush;
        valid = t.valid;
        en    = t.en;
        pc    = t.pc;
        instr = instr_of(t.pc);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; valid = 1'b0; en = 1'b0; pc = '0; instr = '0;

        //  rst flush valid en  pc        count imask ready head_pc
        // reset, then idle
        add(0, 0, 0, 0, 32'd0,    3'd0, 0, 1, 32'd0);
        add(1, 0, 0, 0, 32'd0,    3'd0, 0, 1, 32'd0);
        // fill to four, fifth push dropped, then drain in order
        add(1, 0, 1, 0, 32'd0,    3'd1, 1, 1, 32'd0);
        add(1, 0, 1, 0, 32'd4,    3'd2, 1, 1, 32'd0);
        add(1, 0, 1, 0, 32'd8,    3'd3, 1, 1, 32'd0);
        add(1, 0, 1, 0, 32'd12,   3'd4, 1, 0, 32'd0);
        add(1, 0, 1, 0, 32'd16,   3'd4, 1, 0, 32'd0);
        add(1, 0, 0, 1, 32'd0,    3'd3, 1, 1, 32'd4);
        add(1, 0, 0, 1, 32'd0,    3'd2, 1, 1, 32'd8);
        add(1, 0, 0, 1, 32'd0,    3'd1, 1, 1, 32'd12);
        add(1, 0, 0, 1, 32'd0,    3'd0, 0, 1, 32'd0);
        // steady stream at count=1 for 10 cycles
        add(1, 0, 1, 0, 32'd100,  3'd1, 1, 1, 32'd100);
        for (int k = 1; k <= 10; k++)
            add(1, 0, 1, 1, 32'd100 + 32'(4 * k), 3'd1, 1, 1, 32'd100 + 32'(4 * k));
        // build count=3, then flush with concurrent push and pop
        add(1, 0, 1, 0, 32'd200,  3'd2, 1, 1, 32'd140);
        add(1, 0, 1, 0, 32'd204,  3'd3, 1, 1, 32'd140);
        add(1, 1, 1, 1, 32'd212,  3'd0, 0, 1, 32'd0);
        add(1, 0, 0, 0, 32'd0,    3'd0, 0, 1, 32'd0);
        add(1, 0, 1, 0, 32'd300,  3'd1, 1, 1, 32'd300);
        add(1, 0, 0, 1, 32'd0,    3'd0, 0, 1, 32'd0);
        // pop on empty for three cycles, then a push
        add(1, 0, 0, 1, 32'd0,    3'd0, 0, 1, 32'd0);
        add(1, 0, 0, 1, 32'd0,    3'd0, 0, 1, 32'd0);
        add(1, 0, 0, 1, 32'd0,    3'd0, 0, 1, 32'd0);
        add(1, 0, 1, 0, 32'd400,  3'd1, 1, 1, 32'd400);
        // full boundary: push+pop at count=4 takes only the pop
        add(1, 0, 1, 0, 32'd404,  3'd2, 1, 1, 32'd400);
        add(1, 0, 1, 0, 32'd408,  3'd3, 1, 1, 32'd400);
        add(1, 0, 1, 0, 32'd412,  3'd4, 1, 0, 32'd400);
        add(1, 0, 1, 1, 32'd416,  3'd3, 1, 1, 32'd404);
        add(1, 0, 0, 1, 32'd0,    3'd2, 1, 1, 32'd408);
        add(1, 0, 0, 1, 32'd0,    3'd1, 1, 1, 32'd412);
        add(1, 0, 0, 1, 32'd0,    3'd0, 0, 1, 32'd0);
        // reset mid-stream beats push, pop and flush
        add(1, 0, 1, 0, 32'd500,  3'd1, 1, 1, 32'd500);
        add(1, 0, 1, 0, 32'd504,  3'd2, 1, 1, 32'd500);
        add(0, 1, 1, 1, 32'd508,  3'd0, 0, 1, 32'd0);
        add(1, 0, 0, 0, 32'd0,    3'd0, 0, 1, 32'd0);

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("v%0d count", i), 32'(count),   32'(vecs[i].exp_count));
            check($sformatf("v%0d imask", i), 32'(imask),   32'(vecs[i].exp_imask));
            check($sformatf("v%0d ready", i), 32'(ready),   32'(vecs[i].exp_ready));
            check($sformatf("v%0d pc",    i), o_pc,         vecs[i].exp_pc);
            check($sformatf("v%0d instr", i), o_instr,
                  vecs[i].exp_imask ? instr_of(vecs[i].exp_pc) : NOP);
        end

        // No same-cycle bypass: a push offered to an empty buffer is not visible before the edge.
        drive('{1'b1, 1'b0, 1'b1, 1'b0, 32'd600, 3'd0, 1'b0, 1'b1, 32'd0});
        #2;
        check("bypass imask", 32'(imask), 32'd0);
        check("bypass instr", o_instr, NOP);
        @(posedge clk);
        #1;
        check("after push imask", 32'(imask), 32'd1);
        check("after push pc", o_pc, 32'd600);
        valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fetch_buffer

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries; power of two and at least 2.
REQ-002 SHALL have parameter WIDTH, default 32, instruction width in bits.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_flush  input  1  discard all entries (redirect or mispredict).
REQ-006 SHALL have port i_valid  input  1  fetch presents an instruction this cycle.
REQ-007 SHALL have port i_instr  input  WIDTH  fetched instruction.
REQ-008 SHALL have port i_pc  input  32  PC of i_instr.
REQ-009 SHALL have port o_ready  output  1  buffer can accept a push (not full).
REQ-010 SHALL have port i_en  input  1  decode consumes the head entry this cycle.
REQ-011 SHALL have port o_instr  output  WIDTH  head instruction; feeds decode i_instr.
REQ-012 SHALL have port o_pc  output  32  head PC.
REQ-013 SHALL have port o_imask  output  1  head valid (not empty); feeds decode i_imask.
REQ-014 SHALL have port o_count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL implement a circular FIFO with write pointer, read pointer and occupancy counter, all wrapping modulo DEPTH (counter 0..DEPTH).
REQ-016 SHALL perform a push when i_valid=1 and o_ready=1; entry written at the write pointer; write pointer +1.
REQ-017 SHALL ignore i_valid while full (o_ready=0), including a cycle with a simultaneous pop; no overwrite, no count change from the push.
REQ-018 SHALL perform a pop when i_en=1 and o_imask=1; read pointer +1.
REQ-019 SHALL ignore i_en while empty; pointers and count unchanged.
REQ-020 SHALL, on a simultaneous push and pop while neither full nor empty, advance both pointers and keep count unchanged.
REQ-021 SHALL make a pushed entry visible at the head one cycle after the push edge; there is no same-cycle bypass.
REQ-022 SHALL drive o_ready = (count != DEPTH) and o_imask = (count != 0), derived combinationally from registered count.
REQ-023 SHALL drive o_instr and o_pc from the read-pointer entry when o_imask=1.
REQ-024 SHALL drive o_instr=32'h00000013 (NOP) and o_pc=0 when o_imask=0.
REQ-025 SHALL give i_flush priority over push and pop: next cycle count=0 and both pointers=0, and an instruction offered in the flush cycle is dropped.
REQ-026 SHALL NOT clear storage contents on flush or reset; only pointers and count are cleared.

Reset
REQ-027 SHALL, when i_rst_n=0 at a rising edge, set pointers=0 and count=0, giving o_imask=0, o_ready=1, o_count=0, o_instr=NOP and o_pc=0 from the next cycle.
REQ-028 SHALL give reset priority over i_flush, i_valid and i_en; a reset asserted mid-stream discards all entries.

Structure
REQ-029 SHALL take the NOP encoding (32'h00000013) and the default DEPTH from the shared package; the same constant is used by any stage that inserts bubbles.
REQ-030 SHALL be a single module with no sub-module; storage is an inferred register array.

Verification
REQ-031 SHALL cover reset then idle: o_imask=0, o_ready=1, o_count=0, o_instr=32'h00000013.
REQ-032 SHALL cover filling: push 4 instructions (PC 0,4,8,12) with i_en=0 -> o_count=4, o_ready=0; a 5th push is dropped; then pop 4 -> PCs come out in order 0,4,8,12, then o_imask=0.
REQ-033 SHALL cover steady stream: push and pop every cycle from count=1 over 10 cycles -> o_count stays 1 and PCs wrap through all pointer positions in order.
REQ-034 SHALL cover flush: with count=3 and a concurrent push and pop -> next cycle o_count=0, o_imask=0, and the pushed instruction never appears.
REQ-035 SHALL cover pop on empty: i_en=1 with count=0 for 3 cycles -> count stays 0; a push then gives o_imask=1 exactly one cycle later.
REQ-036 SHALL cover full boundary: push+pop while count=4 -> the pop is taken, the push is dropped, and o_count=3 next cycle.
